// File: rtl/riscv_mini_pipe.sv
// riscv_mini_pipe: two-stage mini RISC-V datapath.
// Stage 1 holds an accepted instruction in the IR.
// Stage 2 executes that instruction against an 8 x WIDTH register file
// and latches one result word into a backpressured output register.
// Optional feature macro: RISCV_MINI_MUL_EN adds X-type funct3 100 (multiply).
module riscv_mini_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [15:0]      instr,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       result_op,
   output logic [2:0]       flags
);

   localparam int SH = $clog2(WIDTH);

   typedef enum logic [1:0] {OP_R = 2'b00, OP_I = 2'b01, OP_L = 2'b10, OP_X = 2'b11} opcode_t;
   typedef enum logic [2:0] {
      F_AND = 3'b000, F_OR  = 3'b001, F_ADD = 3'b010, F_SUB = 3'b011,
      F_XOR = 3'b100, F_SLL = 3'b101, F_SRL = 3'b110, F_SRA = 3'b111
   } funct3_t;

   // Bits 15:14 carry no meaning, so only the low 14 bits are kept.
   logic [13:0]      ir;
   logic             ir_valid;
   logic [WIDTH-1:0] rf [8];

   logic             instr_fire;
   logic             exec_fire;

   opcode_t          opcode;
   funct3_t          funct3;
   logic [2:0]       rs1, rs2, rd, ra1;
   logic [5:0]       imm6;
   logic [WIDTH-1:0] imm_sext;
   logic [WIDTH-1:0] rs1_val, rs2_val;
   logic [WIDTH-1:0] alu_a, alu_b, alu_out;
   logic [SH-1:0]    shamt;
   logic             alu_c;
   logic [WIDTH-1:0] res_d;
   logic             wr_en;
   logic             flags_we;

   assign exec_fire   = ir_valid & (~result_valid | result_ready);
   assign instr_ready = ~ir_valid | exec_fire;
   assign instr_fire  = instr_valid & instr_ready;

   assign opcode   = opcode_t'(ir[1:0]);
   assign rs2      = ir[4:2];
   assign rs1      = ir[7:5];
   assign rd       = ir[10:8];
   assign funct3   = funct3_t'(ir[13:11]);
   assign imm6     = ir[7:2];
   assign imm_sext = {{(WIDTH-6){imm6[5]}}, imm6};

   // I-type reads its own destination through read port 1, so two read ports suffice.
   assign ra1     = (opcode == OP_I) ? rd : rs1;
   assign rs1_val = rf[ra1];
   assign rs2_val = rf[rs2];

   assign alu_a = rs1_val;
   assign alu_b = (opcode == OP_I) ? imm_sext : rs2_val;
   assign shamt = alu_b[SH-1:0];

`ifdef RISCV_MINI_MUL_EN
   logic [WIDTH-1:0] mul_lo;
   // Only the low word of the product is ever used.
   assign mul_lo = rs1_val * rs2_val;
`endif

   // ALU: selected operation plus carry/borrow for the C flag.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      alu_out = '0;
      alu_c   = 1'b0;
      case (funct3)
         F_AND: alu_out = alu_a & alu_b;
         F_OR:  alu_out = alu_a | alu_b;
         F_ADD: {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         F_SUB: begin
            alu_out = alu_a - alu_b;
            alu_c   = (alu_a < alu_b);
         end
         F_XOR: alu_out = alu_a ^ alu_b;
         F_SLL: alu_out = alu_a << shamt;
         F_SRL: alu_out = alu_a >> shamt;
         F_SRA: alu_out = $unsigned($signed(alu_a) >>> shamt);
         default: alu_out = '0;
      endcase
   end

   // Result select and register-file / flag write enables per opcode.
   always_comb begin
      res_d    = '0;
      wr_en    = 1'b0;
      flags_we = 1'b0;
      case (opcode)
         OP_R, OP_I: begin
            res_d    = alu_out;
            wr_en    = 1'b1;
            flags_we = 1'b1;
         end
         OP_L: res_d = rs1_val;
         OP_X: begin
            case (ir[13:11])
               3'b001: res_d = rs2_val;
               3'b010: res_d = {{(WIDTH-1){1'b0}}, (rs1_val == rs2_val)};
               3'b011: res_d = {{(WIDTH-1){1'b0}}, ($signed(rs1_val) < $signed(rs2_val))};
`ifdef RISCV_MINI_MUL_EN
               3'b100: begin
                  res_d = mul_lo;
                  wr_en = 1'b1;
               end
`endif
               default: res_d = '0;
            endcase
         end
         default: res_d = '0;
      endcase
   end

   // Instruction register: load on accept, empty when executed without a refill.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         ir       <= '0;
         ir_valid <= 1'b0;
      end else if (instr_fire) begin
         ir       <= instr[13:0];
         ir_valid <= 1'b1;
      end else if (exec_fire) begin
         ir_valid <= 1'b0;
      end
   end

   // Output register and flags: latch on execute, drop valid once consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         result       <= '0;
         result_op    <= '0;
         result_valid <= 1'b0;
         flags        <= '0;
      end else if (exec_fire) begin
         result       <= res_d;
         result_op    <= ir[1:0];
         result_valid <= 1'b1;
         if (flags_we) flags <= {alu_out[WIDTH-1], alu_c, (alu_out == '0)};
      end else if (result_ready) begin
         result_valid <= 1'b0;
      end
   end

   // Register file write at the end of the execute cycle.
   always_ff @(posedge clk) begin
      // NOTE: this array is cleared on reset because every register must read zero afterwards,
      // which keeps it in flops rather than a RAM macro.
      if (rst) begin
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else if (exec_fire && wr_en) begin
         rf[rd] <= res_d;
      end
   end

endmodule

// File: tb/tb_riscv_mini_pipe.sv
// Self-checking bench for riscv_mini_pipe (WIDTH = 8).
// A table of directed instructions with hand-computed results and flags,
// plus hand-written sequences for back-to-back issue, backpressure,
// mid-stream reset and the optional multiply (RISCV_MINI_MUL_EN).
module tb_riscv_mini_pipe;

   localparam logic [2:0] F_AND = 3'b000, F_OR  = 3'b001, F_ADD = 3'b010, F_SUB = 3'b011;
   localparam logic [2:0] F_XOR = 3'b100, F_SLL = 3'b101, F_SRL = 3'b110, F_SRA = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic        result_valid;
   logic        result_ready = 1'b1;
   logic [7:0]  result;
   logic [1:0]  result_op;
   logic [2:0]  flags;

   int checks = 0;
   int errors = 0;

   logic [15:0] feed[$];

   typedef struct {
      logic [15:0] instr;
      logic [7:0]  res;
      logic [2:0]  flags;
   } vec_t;

   vec_t vecs[32];

   riscv_mini_pipe #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result),
      .result_op    (result_op),
      .flags        (flags)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] enc_r(input logic [2:0] f, input logic [2:0] d,
                                         input logic [2:0] s1, input logic [2:0] s2);
      return {2'b00, f, d, s1, s2, 2'b00};
   endfunction

   function automatic logic [15:0] enc_i(input logic [2:0] f, input logic [2:0] d,
                                         input logic [5:0] imm);
      return {2'b00, f, d, imm, 2'b01};
   endfunction

   function automatic logic [15:0] enc_l(input logic [2:0] s1);
      return {2'b00, 3'b000, 3'b000, s1, 3'b000, 2'b10};
   endfunction

   function automatic logic [15:0] enc_x(input logic [2:0] f, input logic [2:0] d,
                                         input logic [2:0] s1, input logic [2:0] s2);
      return {2'b00, f, d, s1, s2, 2'b11};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_feed();
      if (feed.size() > 0) begin
         instr_valid = 1'b1;
         instr       = feed[0];
      end else begin
         instr_valid = 1'b0;
      end
   endtask

   // One clock: sample handshakes at the falling edge, advance the feed after the rising edge.
   task automatic step(output logic consumed, output logic [7:0] val,
                       output logic [1:0] op, output logic [2:0] fl);
      logic fired;
      drive_feed();
      @(negedge clk);
      fired    = instr_valid & instr_ready;
      consumed = result_valid & result_ready;
      val      = result;
      op       = result_op;
      fl       = flags;
      @(posedge clk);
      #1;
      if (fired) void'(feed.pop_front());
      drive_feed();
   endtask

   task automatic run_one(input string name, input logic [15:0] w,
                          input logic [7:0] exp_res, input logic [2:0] exp_flags);
      logic       consumed;
      logic [7:0] val;
      logic [1:0] op;
      logic [2:0] fl;
      int         n;
      result_ready = 1'b1;
      feed.push_back(w);
      consumed = 1'b0;
      n = 0;
      while (!consumed && n < 20) begin
         step(consumed, val, op, fl);
         n++;
      end
      check({name, " delivered"}, consumed, 1);
      check({name, " result"}, val, exp_res);
      check({name, " op"}, op, w[1:0]);
      check({name, " flags"}, fl, exp_flags);
   endtask

   task automatic do_reset();
      feed.delete();
      instr_valid  = 1'b0;
      result_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic       consumed;
      logic [7:0] val;
      logic [1:0] op;
      logic [2:0] fl;
      int         got;
      int         first_at;
      int         second_at;

      vecs[0]  = '{enc_i(F_AND, 3'd1, 6'h00),         8'h00, 3'b001};
      vecs[1]  = '{enc_i(F_ADD, 3'd1, 6'h1F),         8'h1F, 3'b000};
      vecs[2]  = '{enc_i(F_ADD, 3'd1, 6'h1F),         8'h3E, 3'b000};
      vecs[3]  = '{enc_i(F_ADD, 3'd1, 6'h1F),         8'h5D, 3'b000};
      vecs[4]  = '{enc_i(F_ADD, 3'd1, 6'h1F),         8'h7C, 3'b000};
      vecs[5]  = '{enc_i(F_ADD, 3'd1, 6'h03),         8'h7F, 3'b000};
      vecs[6]  = '{enc_r(F_ADD, 3'd1, 3'd1, 3'd1),    8'hFE, 3'b100};
      vecs[7]  = '{enc_i(F_ADD, 3'd1, 6'h01),         8'hFF, 3'b100};
      vecs[8]  = '{enc_r(F_SUB, 3'd3, 3'd0, 3'd1),    8'h01, 3'b010};
      vecs[9]  = '{enc_i(F_AND, 3'd2, 6'h00),         8'h00, 3'b001};
      vecs[10] = '{enc_i(F_ADD, 3'd2, 6'h01),         8'h01, 3'b000};
      vecs[11] = '{enc_x(3'b011, 3'd0, 3'd1, 3'd2),   8'h01, 3'b000};
      vecs[12] = '{enc_x(3'b010, 3'd0, 3'd1, 3'd1),   8'h01, 3'b000};
      vecs[13] = '{enc_x(3'b010, 3'd0, 3'd1, 3'd2),   8'h00, 3'b000};
      vecs[14] = '{enc_x(3'b011, 3'd0, 3'd2, 3'd1),   8'h00, 3'b000};
      vecs[15] = '{enc_l(3'd1),                       8'hFF, 3'b000};
      vecs[16] = '{enc_l(3'd2),                       8'h01, 3'b000};
      vecs[17] = '{enc_r(F_ADD, 3'd3, 3'd1, 3'd2),    8'h00, 3'b011};
      vecs[18] = '{enc_r(F_XOR, 3'd4, 3'd1, 3'd2),    8'hFE, 3'b100};
      vecs[19] = '{enc_r(F_OR,  3'd5, 3'd2, 3'd3),    8'h01, 3'b000};
      vecs[20] = '{enc_r(F_SLL, 3'd6, 3'd2, 3'd2),    8'h02, 3'b000};
      vecs[21] = '{enc_r(F_SRL, 3'd6, 3'd1, 3'd2),    8'h7F, 3'b000};
      vecs[22] = '{enc_r(F_SRA, 3'd7, 3'd1, 3'd2),    8'hFF, 3'b100};
      vecs[23] = '{enc_r(F_AND, 3'd4, 3'd1, 3'd2),    8'h01, 3'b000};
      vecs[24] = '{enc_r(F_SUB, 3'd3, 3'd2, 3'd2),    8'h00, 3'b001};
      vecs[25] = '{enc_i(F_ADD, 3'd3, 6'h3F),         8'hFF, 3'b100};
      vecs[26] = '{enc_x(3'b001, 3'd0, 3'd0, 3'd4),   8'h01, 3'b100};
      vecs[27] = '{enc_x(3'b000, 3'd0, 3'd1, 3'd1),   8'h00, 3'b100};
      vecs[28] = '{enc_x(3'b101, 3'd0, 3'd1, 3'd1),   8'h00, 3'b100};
      vecs[29] = '{enc_l(3'd3),                       8'hFF, 3'b100};
      vecs[30] = '{enc_r(F_SUB, 3'd0, 3'd2, 3'd1),    8'h02, 3'b010};
      vecs[31] = '{enc_l(3'd0),                       8'h02, 3'b010};

      // Reset state.
      do_reset();
      check("reset result_valid", result_valid, 0);
      check("reset instr_ready", instr_ready, 1);
      check("reset result", result, 0);
      check("reset result_op", result_op, 0);
      check("reset flags", flags, 0);

      // Back-to-back dependent pair: ADDI r1,5 then ADD r2,r1,r1.
      feed.push_back(enc_i(F_ADD, 3'd1, 6'd5));
      feed.push_back(enc_r(F_ADD, 3'd2, 3'd1, 3'd1));
      got = 0;
      first_at = -1;
      second_at = -1;
      for (int c = 0; c < 20 && got < 2; c++) begin
         step(consumed, val, op, fl);
         if (consumed) begin
            check($sformatf("b2b result %0d", got), val, (got == 0) ? 8'd5 : 8'd10);
            check($sformatf("b2b flags %0d", got), fl, 3'b000);
            if (got == 0) first_at = c; else second_at = c;
            got++;
         end
      end
      check("b2b count", got, 2);
      check("b2b first latency", first_at, 2);
      check("b2b second latency", second_at, 3);

      // Directed table.
      do_reset();
      for (int k = 0; k < 32; k++) begin
         run_one($sformatf("vec%0d", k), vecs[k].instr, vecs[k].res, vecs[k].flags);
      end

      // Backpressure: four ADDIs with results 1..4, consumer stalled.
      do_reset();
      result_ready = 1'b0;
      for (int k = 1; k <= 4; k++) feed.push_back(enc_i(F_ADD, 3'(k), 6'(k)));
      step(consumed, val, op, fl);
      step(consumed, val, op, fl);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("stall%0d result_valid", c), result_valid, 1);
         check($sformatf("stall%0d result", c), result, 1);
         check($sformatf("stall%0d instr_ready", c), instr_ready, 0);
         step(consumed, val, op, fl);
      end
      check("stall absorbed", feed.size(), 2);
      result_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         step(consumed, val, op, fl);
         if (consumed) begin
            check($sformatf("drain result %0d", got), val, got + 1);
            got++;
         end
      end
      check("drain count", got, 4);
      step(consumed, val, op, fl);
      check("drain no duplicate", consumed, 0);
      check("drain result_valid", result_valid, 0);

      // Reset while both IR and output register are full.
      do_reset();
      result_ready = 1'b0;
      feed.push_back(enc_i(F_ADD, 3'd1, 6'h3F));
      feed.push_back(enc_i(F_ADD, 3'd2, 6'd5));
      step(consumed, val, op, fl);
      step(consumed, val, op, fl);
      check("pre-rst result_valid", result_valid, 1);
      check("pre-rst instr_ready", instr_ready, 0);
      check("pre-rst flags", flags, 3'b100);
      feed.delete();
      instr_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid-rst result_valid", result_valid, 0);
      check("mid-rst flags", flags, 0);
      check("mid-rst result", result, 0);
      check("mid-rst instr_ready", instr_ready, 1);
      for (int r = 0; r < 8; r++) begin
         run_one($sformatf("rst read r%0d", r), enc_l(3'(r)), 8'h00, 3'b000);
      end

      // Multiply r5 <= r1 * r2 with r1=12, r2=11; flags must stay at ADDI r5,-2's value.
      do_reset();
      run_one("mul setup r1", enc_i(F_ADD, 3'd1, 6'd12), 8'd12, 3'b000);
      run_one("mul setup r2", enc_i(F_ADD, 3'd2, 6'd11), 8'd11, 3'b000);
      run_one("mul setup r5", enc_i(F_ADD, 3'd5, 6'h3E), 8'hFE, 3'b100);
`ifdef RISCV_MINI_MUL_EN
      run_one("mul", enc_x(3'b100, 3'd5, 3'd1, 3'd2), 8'h84, 3'b100);
      run_one("mul rd", enc_l(3'd5), 8'h84, 3'b100);
`else
      run_one("mul nop", enc_x(3'b100, 3'd5, 3'd1, 3'd2), 8'h00, 3'b100);
      run_one("mul rd", enc_l(3'd5), 8'hFE, 3'b100);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
